// File: rtl/activation_output_writer_if.sv
// Row-stream and BRAM write bus of the activation output writer.
// The master side is the upstream activation stage, which also observes the
// BRAM port. The slave side is the writer.
// Optional macro ACT_WR_PING_PONG_EN widens bram_addr by one bank-select MSB.
interface activation_output_writer_if #(
  parameter int DWIDTH      = 16,
  parameter int DESIGN_SIZE = 32,
  parameter int AWIDTH      = 10
);
`ifdef ACT_WR_PING_PONG_EN
  localparam int ADDR_W = AWIDTH + 1;
`else
  localparam int ADDR_W = AWIDTH;
`endif

  logic [DESIGN_SIZE*DWIDTH-1:0] in_data;
  logic                          in_data_available;
  logic                          in_done;
  logic [ADDR_W-1:0]             bram_addr;
  logic [DESIGN_SIZE*DWIDTH-1:0] bram_wdata;
  logic [DESIGN_SIZE-1:0]        bram_we;

  modport master (
    output in_data, in_data_available, in_done,
    input  bram_addr, bram_wdata, bram_we
  );

  modport slave (
    input  in_data, in_data_available, in_done,
    output bram_addr, bram_wdata, bram_we
  );
endinterface

// File: rtl/activation_output_writer.sv
// activation_output_writer: writes each valid row of the activation output
// stream into BRAM at base + row*stride, with per-lane write enables.
// The writer runs one transfer per start pulse and raises a completion pulse.
// It keeps sticky flags for data arriving while idle and for an early in_done.
// Optional macro ACT_WR_PING_PONG_EN adds bank_sel_o. bank_sel_o is the MSB of
// bram_addr. It flips after every transfer that ends without err_short.
//
// state  | meaning
// IDLE   | waiting for start; strobes are dropped and flagged
// ACTIVE | accepting rows until row count reaches num_rows or in_done
// DONE   | one cycle, done_write=1; strobes dropped and flagged
//
// A zero-row transfer spends one cycle in ACTIVE, where the count already
// equals num_rows. Its done_write therefore lands two cycles after start.
module activation_output_writer #(
  parameter int DWIDTH      = 16,
  parameter int DESIGN_SIZE = 32,
  parameter int AWIDTH      = 10,
  parameter int RWIDTH      = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start_i,
  input  logic [AWIDTH-1:0]         base_addr_i,
  input  logic [AWIDTH-1:0]         stride_i,
  input  logic [RWIDTH-1:0]         num_rows_i,
  input  logic [DESIGN_SIZE-1:0]    lane_mask_i,
  activation_output_writer_if.slave wr_if,
  output logic                      busy_o,
  output logic                      done_write_o,
  output logic                      err_idle_data_o,
  output logic                      err_short_o
`ifdef ACT_WR_PING_PONG_EN
  ,
  output logic                      bank_sel_o
`endif
);

`ifdef ACT_WR_PING_PONG_EN
  localparam int ADDR_W = AWIDTH + 1;
`else
  localparam int ADDR_W = AWIDTH;
`endif
  localparam int W = DESIGN_SIZE * DWIDTH;

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic [AWIDTH-1:0]      stride_q, stride_d;
  logic [RWIDTH-1:0]      num_rows_q, num_rows_d;
  logic [DESIGN_SIZE-1:0] mask_q, mask_d;
  logic [AWIDTH-1:0]      addr_q, addr_d;
  logic [RWIDTH-1:0]      row_cnt_q, row_cnt_d;
  logic [ADDR_W-1:0]      bram_addr_q, bram_addr_d;
  logic [W-1:0]           bram_wdata_q, bram_wdata_d;
  logic [DESIGN_SIZE-1:0] bram_we_q, bram_we_d;
  logic                   err_idle_q, err_idle_d;
  logic                   err_short_q, err_short_d;
  logic [ADDR_W-1:0]      wr_addr;

`ifdef ACT_WR_PING_PONG_EN
  logic bank_q;

  // Bank bit is captured with each write so the last write of a transfer
  // still lands in the old bank even though the bank flips in DONE.
  assign wr_addr = {bank_q, addr_q};

  // Flip to the other bank once a transfer finishes cleanly.
  always_ff @(posedge clk) begin
    if (reset) begin
      bank_q <= 1'b0;
    end else if (state_q == S_DONE && !err_short_q) begin
      bank_q <= ~bank_q;
    end
  end

  assign bank_sel_o = bank_q;
`else
  assign wr_addr = addr_q;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, config latch, row counting and write staging.
  always_comb begin
    state_d      = state_q;
    stride_d     = stride_q;
    num_rows_d   = num_rows_q;
    mask_d       = mask_q;
    addr_d       = addr_q;
    row_cnt_d    = row_cnt_q;
    bram_addr_d  = bram_addr_q;
    bram_wdata_d = bram_wdata_q;
    bram_we_d    = '0;
    err_idle_d   = err_idle_q;
    err_short_d  = err_short_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          stride_d    = stride_i;
          num_rows_d  = num_rows_i;
          mask_d      = lane_mask_i;
          addr_d      = base_addr_i;
          row_cnt_d   = '0;
          err_idle_d  = 1'b0;
          err_short_d = 1'b0;
          state_d     = S_ACTIVE;
        end
        if (wr_if.in_data_available) begin
          err_idle_d = 1'b1;
        end
      end
      S_ACTIVE: begin
        if (wr_if.in_data_available && (row_cnt_q != num_rows_q)) begin
          bram_we_d    = mask_q;
          bram_wdata_d = wr_if.in_data;
          bram_addr_d  = wr_addr;
          addr_d       = addr_q + stride_q;
          row_cnt_d    = row_cnt_q + 1'b1;
        end
        // A row accepted together with in_done counts before the short check.
        if (row_cnt_d == num_rows_q) begin
          state_d = S_DONE;
        end else if (wr_if.in_done) begin
          err_short_d = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (wr_if.in_data_available) begin
          err_idle_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Datapath registers; reset clears config, counters, outputs and flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      stride_q     <= '0;
      num_rows_q   <= '0;
      mask_q       <= '0;
      addr_q       <= '0;
      row_cnt_q    <= '0;
      bram_addr_q  <= '0;
      bram_wdata_q <= '0;
      bram_we_q    <= '0;
      err_idle_q   <= 1'b0;
      err_short_q  <= 1'b0;
    end else begin
      stride_q     <= stride_d;
      num_rows_q   <= num_rows_d;
      mask_q       <= mask_d;
      addr_q       <= addr_d;
      row_cnt_q    <= row_cnt_d;
      bram_addr_q  <= bram_addr_d;
      bram_wdata_q <= bram_wdata_d;
      bram_we_q    <= bram_we_d;
      err_idle_q   <= err_idle_d;
      err_short_q  <= err_short_d;
    end
  end

  assign wr_if.bram_addr  = bram_addr_q;
  assign wr_if.bram_wdata = bram_wdata_q;
  assign wr_if.bram_we    = bram_we_q;
  assign busy_o           = (state_q != S_IDLE);
  assign done_write_o     = (state_q == S_DONE);
  assign err_idle_data_o  = err_idle_q;
  assign err_short_o      = err_short_q;

endmodule
